// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: enumerates every WIDTH-bit word with exactly k bits set,
// in strictly ascending order, over a valid/ready stream. The successor of a
// word is found with the classic "next permutation with the same popcount"
// bit trick, using a priority encoder for the trailing-zero count.
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] numones,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_byte,
  output logic             out_last,
  output logic             err
);

  localparam int TZ_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] succ_w;

  // Smallest word with k ones: all ones packed at the LSB end.
  function automatic logic [WIDTH-1:0] first_word(input logic [CNT_W-1:0] k);
    logic [WIDTH:0] one_w;
    one_w = (WIDTH + 1)'(1);
    return WIDTH'((one_w << k) - one_w);
  endfunction

  // Largest word with k ones: all ones packed at the MSB end.
  function automatic logic [WIDTH-1:0] last_word(input logic [CNT_W-1:0] k);
    return first_word(k) << (CNT_W'(WIDTH) - k);
  endfunction

  // Next-larger word with the same popcount. One extra bit keeps the carry
  // out of the ripple add so the shifted-down run of ones is computed right.
  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] v);
    logic [WIDTH:0]  v1;
    logic [WIDTH:0]  c;
    logic [WIDTH:0]  r;
    logic [WIDTH:0]  x;
    logic [TZ_W-1:0] tz;
    v1 = {1'b0, v};
    c  = v1 & (-v1);
    r  = v1 + c;
    x  = (r ^ v1) >> 2;
    tz = '0;
    // c is one-hot, so a priority encoder yields its bit index directly.
    for (int i = WIDTH; i >= 0; i--) begin
      if (c[i]) tz = TZ_W'(i);
    end
    return WIDTH'(r | (x >> tz));
  endfunction

  assign succ_w = next_word(word_q);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept/reject start in IDLE, advance or finish on handshake in EMIT.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (numones > CNT_W'(WIDTH)) begin
            err_d = 1'b1;
          end else begin
            k_d     = numones;
            word_d  = first_word(numones);
            last_d  = (first_word(numones) == last_word(numones));
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            // Final word taken: drop back to IDLE, word value is held.
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            word_d = succ_w;
            last_d = (succ_w == last_word(k_q));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == EMIT);
  assign out_valid = (state_q == EMIT);
  assign out_byte  = word_q;
  assign out_last  = last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: table of per-k expectations driving
// full enumerations, plus hand sequences for error, backpressure and reset.
module tb_ones_pattern_gen;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] numones;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    int         k;
    int         beats;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  vec_t tbl[9];

  ones_pattern_gen #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .numones   (numones),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference successor: linear search for the next word with k ones.
  function automatic logic [7:0] model_next(input logic [7:0] v, input int k);
    for (int x = int'(v) + 1; x < 256; x++) begin
      if ($countones(8'(x)) == k) return 8'(x);
    end
    return 8'h00;
  endfunction

  // Run one full enumeration of table entry i. rnd randomises out_ready;
  // poke fires stray starts mid-stream and on the final handshake.
  task automatic run_enum(input int i, input bit rnd, input bit poke);
    int         k;
    int         beats;
    int         cyc;
    bit         done;
    bit         prev_stall;
    logic [7:0] exp_w;
    logic [7:0] prev_w;
    logic       prev_l;
    k          = tbl[i].k;
    beats      = 0;
    cyc        = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_w     = '0;
    prev_l     = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    numones = 4'(k);
    @(negedge clk);
    start   = 1'b0;
    numones = 4'((k + 3) % 9);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    chk("first_word", 32'(out_byte), 32'(tbl[i].first));
    exp_w = tbl[i].first;
    while (!done && cyc < 2000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      start = 1'b0;
      chk("no_err", 32'(err), 32'd0);
      if (prev_stall) begin
        chk("stall_word", 32'(out_byte), 32'(prev_w));
        chk("stall_last", 32'(out_last), 32'(prev_l));
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        beats++;
        chk("popcount", 32'($countones(out_byte)), 32'(k));
        chk("word", 32'(out_byte), 32'(exp_w));
        chk("last_flag", 32'(out_last), 32'(beats == tbl[i].beats));
        if (out_last) begin
          chk("beats", 32'(beats), 32'(tbl[i].beats));
          chk("last_word", 32'(out_byte), 32'(tbl[i].last));
          done = 1'b1;
          if (poke) begin
            start   = 1'b1;
            numones = 4'(k);
          end
        end else begin
          exp_w = model_next(out_byte, k);
          if (poke && beats == 3) begin
            start   = 1'b1;
            numones = 4'((k + 1) % 9);
          end
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid;
      end
      prev_w = out_byte;
      prev_l = out_last;
    end
    chk("enum_done", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_off", 32'(busy), 32'd0);
    chk("valid_off", 32'(out_valid), 32'd0);
    chk("last_off", 32'(out_last), 32'd0);
    chk("word_held", 32'(out_byte), 32'(tbl[i].last));
    chk("no_err_end", 32'(err), 32'd0);
    $display("enum k=%0d beats=%0d done=%0d", k, beats, done);
  endtask

  initial begin
    tbl[0] = '{0, 1,  8'h00, 8'h00};
    tbl[1] = '{1, 8,  8'h01, 8'h80};
    tbl[2] = '{2, 28, 8'h03, 8'hC0};
    tbl[3] = '{3, 56, 8'h07, 8'hE0};
    tbl[4] = '{4, 70, 8'h0F, 8'hF0};
    tbl[5] = '{5, 56, 8'h1F, 8'hF8};
    tbl[6] = '{6, 28, 8'h3F, 8'hFC};
    tbl[7] = '{7, 8,  8'h7F, 8'hFE};
    tbl[8] = '{8, 1,  8'hFF, 8'hFF};

    reset_n   = 1'b0;
    start     = 1'b0;
    numones   = 4'd0;
    out_ready = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word", 32'(out_byte), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // k=2 with constant ready, then the single-beat cases.
    run_enum(2, 1'b0, 1'b0);
    run_enum(0, 1'b0, 1'b0);
    run_enum(8, 1'b0, 1'b0);

    // Out-of-range request: one-cycle err, no output.
    @(negedge clk);
    start   = 1'b1;
    numones = 4'd9;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_valid", 32'(out_valid), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_clear", 32'(err), 32'd0);
    chk("err_idle", 32'(busy), 32'd0);
    $display("err sequence numones=9 done");
    run_enum(1, 1'b0, 1'b0);

    // k=1 under random backpressure.
    run_enum(1, 1'b1, 1'b0);

    // k=4 aborted by reset mid-stream, then restarted.
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    numones   = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_word", 32'(out_byte), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    $display("async reset mid-enumeration applied");
    @(negedge clk);
    reset_n = 1'b1;
    run_enum(4, 1'b0, 1'b0);

    // Full sweep with stray starts during EMIT and on the final handshake.
    for (int i = 0; i < 9; i++) begin
      run_enum(i, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
